// File: rtl/gpio_conv_sequencer_pkg.sv
// gpio_conv_sequencer_pkg
// Shared definitions for the GPIO convolution command sequencer:
//   - opcode constants carried in the command word
//   - command word and status word bit positions
//   - sequencer state encoding and LED patterns
package gpio_conv_sequencer_pkg;

    // Command word layout (processor -> sequencer)
    localparam int CMD_OP_HI   = 31;
    localparam int CMD_OP_LO   = 29;
    localparam int CMD_TOGGLE  = 28;
    localparam int CMD_PL_HI   = 27;
    localparam int KIDX_HI     = 11;
    localparam int KIDX_LO     = 8;

    // Status word layout (sequencer -> processor)
    localparam int ST_ACK      = 31;
    localparam int ST_BUSY     = 30;
    localparam int ST_DONE     = 29;
    localparam int ST_ERROR    = 28;

    localparam logic [2:0] OP_NOP       = 3'd0;
    localparam logic [2:0] OP_SOFT_RST  = 3'd1;
    localparam logic [2:0] OP_SET_WIDTH = 3'd2;
    localparam logic [2:0] OP_WR_KERNEL = 3'd3;
    localparam logic [2:0] OP_WR_PIXEL  = 3'd4;
    localparam logic [2:0] OP_START     = 3'd5;
    localparam logic [2:0] OP_RD_PIXEL  = 3'd6;
    localparam logic [2:0] OP_RD_STATUS = 3'd7;

    // A 3x3 kernel has coefficients 0..8
    localparam logic [3:0] KERNEL_IDX_MAX = 4'd8;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_EXEC    = 2'd1,
        S_RUN     = 2'd2,
        S_RD_WAIT = 2'd3
    } seq_state_t;

    localparam logic [2:0] LED_IDLE    = 3'b001;
    localparam logic [2:0] LED_EXEC    = 3'b010;
    localparam logic [2:0] LED_RUN     = 3'b100;
    localparam logic [2:0] LED_RD_WAIT = 3'b011;
    localparam logic [2:0] LED_ERROR   = 3'b111;

endpackage

// File: rtl/gpio_toggle_detect.sv
// gpio_toggle_detect
// Registers the command toggle bit and captures the command word whenever
// the toggle differs from its registered copy. The captured command stays
// pending until the sequencer takes it; while one command is pending no
// further toggle change is captured, so at most one command waits.
// Ports:
//   i_clk, i_rst  clock, asynchronous active-high reset
//   i_word        raw command word from processor GPIO
//   i_take        sequencer consumes the pending command this cycle
//   o_pending     a captured command is waiting
//   o_word        captured command word
module gpio_toggle_detect
    import gpio_conv_sequencer_pkg::*;
#(
    parameter int NB_GPIO = 32
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [NB_GPIO-1:0] i_word,
    input  logic               i_take,
    output logic               o_pending,
    output logic [NB_GPIO-1:0] o_word
);

    logic               r_toggle;
    logic               r_pending;
    logic [NB_GPIO-1:0] r_word;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_toggle  <= 1'b0;
            r_pending <= 1'b0;
            r_word    <= '0;
        end else begin
            if (i_take) begin
                r_pending <= 1'b0;
            end
            // A change is only latched into a free slot; otherwise it stays
            // visible on i_word and is picked up once the slot is empty.
            if (!r_pending && (i_word[CMD_TOGGLE] != r_toggle)) begin
                r_toggle  <= i_word[CMD_TOGGLE];
                r_pending <= 1'b1;
                r_word    <= i_word;
            end
        end
    end

    assign o_pending = r_pending;
    assign o_word    = r_word;

endmodule

// File: rtl/gpio_conv_sequencer.sv
// gpio_conv_sequencer
// Command sequencer between the MicroBlaze GPIO pair and the convolution
// datapath. Decodes toggle-handshaked commands (set width, write kernel,
// write pixel, start, read pixel, status, soft reset) and reports ack,
// busy, done, error and read data on the GPIO input word.
// Optional feature: define CONV_TIMEOUT_EN to add a RUN watchdog that ends
// a convolution with error after TIMEOUT_CYCLES cycles without i_conv_done.
// Ports:
//   i_CLK, i_rst            clock, asynchronous active-high reset
//   i_gpio_data/o_gpio_data command word in, status/readback word out
//   o_mem_we/addr/wdata     image memory write port (addr also reads)
//   i_mem_rdata             result memory data, 1-cycle read latency
//   o_img_width             configured image width
//   o_kernel_we/idx/coeff   kernel coefficient write port
//   o_conv_start            one-cycle start pulse
//   i_conv_done             datapath completion, sampled in RUN only
//   o_led                   state indicator (111 while error is set)
module gpio_conv_sequencer
    import gpio_conv_sequencer_pkg::*;
#(
    parameter int NB_GPIO        = 32,
    parameter int NB_ADDRESS     = 10,
    parameter int NB_IMAGE       = 10,
    parameter int NB_COEFF       = 8,
    parameter int TIMEOUT_CYCLES = 1048576
) (
    input  logic                  i_CLK,
    input  logic                  i_rst,
    input  logic [NB_GPIO-1:0]    i_gpio_data,
    output logic [NB_GPIO-1:0]    o_gpio_data,
    output logic                  o_mem_we,
    output logic [NB_ADDRESS-1:0] o_mem_addr,
    output logic [NB_IMAGE-1:0]   o_mem_wdata,
    input  logic [NB_IMAGE-1:0]   i_mem_rdata,
    output logic [NB_ADDRESS-1:0] o_img_width,
    output logic                  o_kernel_we,
    output logic [3:0]            o_kernel_idx,
    output logic [NB_COEFF-1:0]   o_kernel_coeff,
    output logic                  o_conv_start,
    input  logic                  i_conv_done,
    output logic [2:0]            o_led
);

    seq_state_t            r_state, w_next_state;
    logic                  w_pending, w_take;
    logic [NB_GPIO-1:0]    w_pend_word;
    logic [2:0]            w_pend_op;
    logic                  w_pend_tog;
    logic [2:0]            r_cmd_op;
    logic                  r_cmd_tog;
    logic [CMD_PL_HI:0]    r_cmd_payload;
    logic [NB_ADDRESS-1:0] r_wr_ptr, r_img_width;
    logic [NB_IMAGE-1:0]   r_rdata;
    logic                  r_ack, r_err, r_done;
    logic                  w_soft_rst, w_run_done, w_run_cmd, w_timeout;
    logic                  w_exec, w_kernel_ok;
    logic                  w_unused_payload;

    gpio_toggle_detect #(.NB_GPIO(NB_GPIO)) u_toggle (
        .i_clk     (i_CLK),
        .i_rst     (i_rst),
        .i_word    (i_gpio_data),
        .i_take    (w_take),
        .o_pending (w_pending),
        .o_word    (w_pend_word)
    );

    assign w_pend_op   = w_pend_word[CMD_OP_HI:CMD_OP_LO];
    assign w_pend_tog  = w_pend_word[CMD_TOGGLE];
    assign w_exec      = (r_state == S_EXEC);
    assign w_kernel_ok = (r_cmd_payload[KIDX_HI:KIDX_LO] <= KERNEL_IDX_MAX);
    assign w_unused_payload = ^r_cmd_payload[CMD_PL_HI:KIDX_HI+1];

`ifdef CONV_TIMEOUT_EN
    localparam int TMR_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [TMR_W-1:0] r_timer;

    // Counts RUN cycles; leaving RUN clears it, so every RUN entry starts at 0.
    always_ff @(posedge i_CLK or posedge i_rst) begin
        if (i_rst) begin
            r_timer <= '0;
        end else if (r_state != S_RUN) begin
            r_timer <= '0;
        end else begin
            r_timer <= r_timer + 1'b1;
        end
    end

    assign w_timeout = (r_state == S_RUN) && (r_timer == TMR_W'(TIMEOUT_CYCLES - 1));
`else
    logic w_unused_timeout;
    assign w_unused_timeout = (TIMEOUT_CYCLES != 0);
    assign w_timeout        = 1'b0;
`endif

    always_ff @(posedge i_CLK or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state and per-cycle control. In RUN, done wins over the watchdog,
    // which wins over a pending command; a command pending alongside done is
    // left for IDLE to execute normally.
    always_comb begin
        w_next_state = r_state;
        w_take       = 1'b0;
        w_soft_rst   = 1'b0;
        w_run_done   = 1'b0;
        w_run_cmd    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_pending) begin
                    w_take       = 1'b1;
                    w_next_state = S_EXEC;
                end
            end
            S_EXEC: begin
                w_soft_rst = (r_cmd_op == OP_SOFT_RST);
                if (r_cmd_op == OP_START) begin
                    w_next_state = S_RUN;
                end else if (r_cmd_op == OP_RD_PIXEL) begin
                    w_next_state = S_RD_WAIT;
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            S_RD_WAIT: w_next_state = S_IDLE;
            S_RUN: begin
                if (i_conv_done) begin
                    w_run_done   = 1'b1;
                    w_next_state = S_IDLE;
                end else if (w_timeout) begin
                    w_next_state = S_IDLE;
                end else if (w_pending) begin
                    w_take = 1'b1;
                    if (w_pend_op == OP_SOFT_RST) begin
                        w_soft_rst   = 1'b1;
                        w_next_state = S_IDLE;
                    end else begin
                        w_run_cmd = 1'b1;
                    end
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // Command register and status state. Ack is written on the edge where
    // the command's effect becomes visible.
    always_ff @(posedge i_CLK or posedge i_rst) begin
        if (i_rst) begin
            r_cmd_op      <= OP_NOP;
            r_cmd_tog     <= 1'b0;
            r_cmd_payload <= '0;
            r_wr_ptr      <= '0;
            r_img_width   <= '0;
            r_rdata       <= '0;
            r_ack         <= 1'b0;
            r_err         <= 1'b0;
            r_done        <= 1'b0;
        end else if (w_soft_rst) begin
            r_wr_ptr    <= '0;
            r_img_width <= '0;
            r_rdata     <= '0;
            r_err       <= 1'b0;
            r_done      <= 1'b0;
            r_ack       <= w_exec ? r_cmd_tog : w_pend_tog;
        end else begin
            if (w_take) begin
                r_cmd_op      <= w_pend_op;
                r_cmd_tog     <= w_pend_tog;
                r_cmd_payload <= w_pend_word[CMD_PL_HI:0];
            end
            case (r_state)
                S_EXEC: begin
                    if (r_cmd_op != OP_RD_PIXEL) begin
                        r_ack <= r_cmd_tog;
                    end
                    case (r_cmd_op)
                        OP_SET_WIDTH: begin
                            r_img_width <= r_cmd_payload[NB_ADDRESS-1:0];
                            r_wr_ptr    <= '0;
                        end
                        OP_WR_KERNEL: if (!w_kernel_ok) r_err <= 1'b1;
                        OP_WR_PIXEL:  r_wr_ptr <= r_wr_ptr + 1'b1;
                        OP_START: begin
                            r_done <= 1'b0;
                            r_err  <= 1'b0;
                        end
                        default: ;
                    endcase
                end
                S_RD_WAIT: begin
                    r_rdata <= i_mem_rdata;
                    r_ack   <= r_cmd_tog;
                end
                S_RUN: begin
                    if (w_run_done) begin
                        r_done <= 1'b1;
                    end else if (w_timeout) begin
                        r_err  <= 1'b1;
                        r_done <= 1'b0;
                    end else if (w_run_cmd) begin
                        r_ack <= w_pend_tog;
                        if (w_pend_op != OP_RD_STATUS) r_err <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_mem_we       = w_exec && (r_cmd_op == OP_WR_PIXEL);
    assign o_kernel_we    = w_exec && (r_cmd_op == OP_WR_KERNEL) && w_kernel_ok;
    assign o_conv_start   = w_exec && (r_cmd_op == OP_START);
    assign o_mem_addr     = (w_exec && (r_cmd_op == OP_RD_PIXEL)) ?
                            r_cmd_payload[NB_ADDRESS-1:0] : r_wr_ptr;
    assign o_mem_wdata    = o_mem_we ? r_cmd_payload[NB_IMAGE-1:0] : '0;
    assign o_kernel_idx   = o_kernel_we ? r_cmd_payload[KIDX_HI:KIDX_LO] : '0;
    assign o_kernel_coeff = o_kernel_we ? r_cmd_payload[NB_COEFF-1:0] : '0;
    assign o_img_width    = r_img_width;

    always_comb begin
        o_gpio_data                 = '0;
        o_gpio_data[ST_ACK]         = r_ack;
        o_gpio_data[ST_BUSY]        = (r_state == S_RUN);
        o_gpio_data[ST_DONE]        = r_done;
        o_gpio_data[ST_ERROR]       = r_err;
        o_gpio_data[NB_IMAGE-1:0]   = r_rdata;
    end

    always_comb begin
        o_led = LED_IDLE;
        if (r_err) begin
            o_led = LED_ERROR;
        end else begin
            case (r_state)
                S_IDLE:    o_led = LED_IDLE;
                S_EXEC:    o_led = LED_EXEC;
                S_RUN:     o_led = LED_RUN;
                S_RD_WAIT: o_led = LED_RD_WAIT;
                default:   o_led = LED_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gpio_conv_sequencer.sv
// tb_gpio_conv_sequencer
// Scoreboard bench: the driver predicts each command's effect with a
// command-level model and queues the expected strobes and status words;
// a monitor pops and compares whenever the DUT shows a strobe or ack edge.
module tb_gpio_conv_sequencer;

    localparam int TMO = 50;

    localparam logic [2:0] C_NOP = 3'd0, C_SRST = 3'd1, C_WIDTH = 3'd2, C_KER = 3'd3;
    localparam logic [2:0] C_PIX = 3'd4, C_START = 3'd5, C_RD = 3'd6, C_STAT = 3'd7;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] gpio_in;
    logic [31:0] gpio_out;
    logic        mem_we;
    logic [9:0]  mem_addr;
    logic [9:0]  mem_wdata;
    logic [9:0]  mem_rdata;
    logic [9:0]  img_width;
    logic        kernel_we;
    logic [3:0]  kernel_idx;
    logic [7:0]  kernel_coeff;
    logic        conv_start;
    logic        conv_done;
    logic [2:0]  led;

    gpio_conv_sequencer #(.TIMEOUT_CYCLES(TMO)) dut (
        .i_CLK          (clk),
        .i_rst          (rst),
        .i_gpio_data    (gpio_in),
        .o_gpio_data    (gpio_out),
        .o_mem_we       (mem_we),
        .o_mem_addr     (mem_addr),
        .o_mem_wdata    (mem_wdata),
        .i_mem_rdata    (mem_rdata),
        .o_img_width    (img_width),
        .o_kernel_we    (kernel_we),
        .o_kernel_idx   (kernel_idx),
        .o_kernel_coeff (kernel_coeff),
        .o_conv_start   (conv_start),
        .i_conv_done    (conv_done),
        .o_led          (led)
    );

    // Clock and image memory environment
    always #5 clk = ~clk;

    logic [9:0] env_mem [1024];
    always @(posedge clk) begin
        if (mem_we) env_mem[mem_addr] <= mem_wdata;
        mem_rdata <= env_mem[mem_addr];
    end

    // Scoreboard queues
    logic [19:0] exp_mem_q [$];
    logic [11:0] exp_ker_q [$];
    logic [0:0]  exp_start_q [$];
    logic [31:0] exp_stat_q [$];
    int total = 0;
    int bad   = 0;

    // Command-level reference model
    logic       m_tog, m_err, m_done, m_run;
    logic [9:0] m_ptr, m_width, m_rd;
    logic [9:0] m_img [1024];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] exp_status();
        logic [31:0] s;
        s = '0;
        s[31] = m_tog;
        s[30] = m_run;
        s[29] = m_done;
        s[28] = m_err;
        s[9:0] = m_rd;
        return s;
    endfunction

    task automatic model_clear();
        m_ptr = '0; m_width = '0; m_rd = '0;
        m_err = 1'b0; m_done = 1'b0; m_run = 1'b0;
    endtask

    // Monitor: compares every strobe and every ack edge against the queues
    logic prev_ack = 1'b0;
    always @(negedge clk) begin
        if (rst) begin
            prev_ack = 1'b0;
        end else begin
            if (mem_we) begin
                if (exp_mem_q.size() == 0) check("mem_we_unexpected", {mem_addr, mem_wdata}, 0);
                else check("mem_write", {mem_addr, mem_wdata}, exp_mem_q.pop_front());
            end
            if (kernel_we) begin
                if (exp_ker_q.size() == 0) check("kernel_we_unexpected", {kernel_idx, kernel_coeff}, 0);
                else check("kernel_write", {kernel_idx, kernel_coeff}, exp_ker_q.pop_front());
            end
            if (conv_start) begin
                if (exp_start_q.size() == 0) check("conv_start_unexpected", 1, 0);
                else check("conv_start", conv_start, exp_start_q.pop_front());
            end
            if (gpio_out[31] != prev_ack) begin
                prev_ack = gpio_out[31];
                if (exp_stat_q.size() == 0) check("ack_unexpected", gpio_out, 0);
                else check("status_at_ack", gpio_out, exp_stat_q.pop_front());
            end
        end
    end

    // Driver: predict, drive one command, wait (bounded) for its ack
    task automatic send_cmd(input logic [2:0] op, input logic [27:0] pl, input bit with_done);
        bit got;
        if (with_done) begin
            m_run = 1'b0;
            m_done = 1'b1;
        end
        m_tog = ~m_tog;
        if (m_run) begin
            if (op == C_SRST) model_clear();
            else if (op != C_STAT) m_err = 1'b1;
        end else begin
            case (op)
                C_SRST:  model_clear();
                C_WIDTH: begin m_width = pl[9:0]; m_ptr = '0; end
                C_KER: begin
                    if (pl[11:8] <= 4'd8) exp_ker_q.push_back({pl[11:8], pl[7:0]});
                    else m_err = 1'b1;
                end
                C_PIX: begin
                    exp_mem_q.push_back({m_ptr, pl[9:0]});
                    m_img[m_ptr] = pl[9:0];
                    m_ptr = m_ptr + 10'd1;
                end
                C_START: begin
                    exp_start_q.push_back(1'b1);
                    m_err = 1'b0; m_done = 1'b0; m_run = 1'b1;
                end
                C_RD:    m_rd = m_img[pl[9:0]];
                default: ;
            endcase
        end
        exp_stat_q.push_back(exp_status());
        @(negedge clk);
        gpio_in = {op, m_tog, pl};
        if (with_done) conv_done = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            conv_done = 1'b0;
            if (gpio_out[31] == m_tog) begin
                got = 1'b1;
                break;
            end
        end
        check("ack_seen", got, 1);
        check("img_width", img_width, m_width);
    endtask

    // Hold RUN for d cycles counting busy, then pulse i_conv_done
    task automatic run_to_done(input int d, output int busy_cnt);
        busy_cnt = 0;
        for (int i = 0; i < d; i++) begin
            if (gpio_out[30]) busy_cnt++;
            @(negedge clk);
        end
        conv_done = 1'b1;
        @(negedge clk);
        conv_done = 1'b0;
        m_run = 1'b0;
        m_done = 1'b1;
        check("done_busy_clear", gpio_out[30:29], 2'b01);
    endtask

    initial begin
        int cnt;
        logic [27:0] pl;
        int r;
        for (int i = 0; i < 1024; i++) begin
            env_mem[i] = '0;
            m_img[i] = '0;
        end
        rst = 1'b1; gpio_in = '0; conv_done = 1'b0; m_tog = 1'b0;
        model_clear();
        repeat (3) @(negedge clk);
        check("rst_gpio", gpio_out, 0);
        check("rst_led", led, 3'b001);
        check("rst_strobes", {mem_we, kernel_we, conv_start}, 0);
        check("rst_addr_width", {mem_addr, img_width, mem_wdata}, 0);
        check("rst_kernel", {kernel_idx, kernel_coeff}, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // width and three pixels
        send_cmd(C_WIDTH, 28'd64, 0);
        send_cmd(C_PIX, 28'd5, 0);
        send_cmd(C_PIX, 28'd6, 0);
        send_cmd(C_PIX, 28'd7, 0);

        // kernel write, then out-of-range index
        send_cmd(C_KER, 28'h47F, 0);
        check("led_idle", led, 3'b001);
        send_cmd(C_KER, 28'h955, 0);
        check("led_error", led, 3'b111);

        // convolution of 100 cycles
        send_cmd(C_START, 28'd0, 0);
        check("led_run", led, 3'b100);
        run_to_done(100, cnt);
        check("busy_cycles", cnt, 100);
        check("led_after_done", led, 3'b001);

        // commands during RUN, then soft reset from RUN
        send_cmd(C_START, 28'd0, 0);
        send_cmd(C_PIX, 28'd9, 0);
        check("led_run_err", led, 3'b111);
        send_cmd(C_STAT, 28'd0, 0);
        send_cmd(C_SRST, 28'd0, 0);
        check("led_after_srst", led, 3'b001);
        send_cmd(C_PIX, 28'h11, 0);

        // pixel readback
        send_cmd(C_WIDTH, 28'd64, 0);
        send_cmd(C_PIX, 28'd1, 0);
        send_cmd(C_PIX, 28'd2, 0);
        send_cmd(C_PIX, 28'd3, 0);
        send_cmd(C_PIX, 28'h2A, 0);
        send_cmd(C_RD, 28'd3, 0);
        check("rd_data", gpio_out[9:0], 10'h2A);

        // done and a new command arriving together
        send_cmd(C_START, 28'd0, 0);
        repeat (5) @(negedge clk);
        send_cmd(C_PIX, 28'h155, 1);
        check("led_after_sim", led, 3'b001);

        // pointer wrap
        send_cmd(C_WIDTH, 28'hFFF0010, 0);
        for (int i = 0; i < 1024; i++) send_cmd(C_PIX, 28'($urandom()), 0);
        send_cmd(C_PIX, 28'h3FF, 0);

        // randomized command mix
        for (int n = 0; n < 120; n++) begin
            r = $urandom_range(0, 19);
            pl = 28'($urandom());
            if (r == 0) send_cmd(C_NOP, pl, 0);
            else if (r == 1) send_cmd(C_SRST, pl, 0);
            else if (r <= 3) send_cmd(C_WIDTH, pl, 0);
            else if (r <= 6) begin
                pl[11:8] = 4'($urandom_range(0, 10));
                send_cmd(C_KER, pl, 0);
            end else if (r <= 11) send_cmd(C_PIX, pl, 0);
            else if (r <= 14) begin
                pl[9:0] = 10'($urandom_range(0, 15));
                send_cmd(C_RD, pl, 0);
            end else if (r <= 16) send_cmd(C_STAT, pl, 0);
            else begin
                send_cmd(C_START, pl, 0);
                run_to_done($urandom_range(1, 30), cnt);
            end
        end

`ifdef CONV_TIMEOUT_EN
        send_cmd(C_START, 28'd0, 0);
        cnt = 0;
        for (int i = 0; i < 200 && gpio_out[30]; i++) begin
            cnt++;
            @(negedge clk);
        end
        m_run = 1'b0; m_err = 1'b1; m_done = 1'b0;
        check("timeout_cycles", cnt, TMO);
        check("timeout_led", led, 3'b111);
        check("timeout_flags", gpio_out[30:28], 3'b001);
`endif

        // asynchronous reset in the middle of RUN
        send_cmd(C_START, 28'd0, 0);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        gpio_in = '0;
        #1;
        check("midrst_gpio", gpio_out, 0);
        check("midrst_led", led, 3'b001);
        check("midrst_strobes", {mem_we, kernel_we, conv_start}, 0);
        check("midrst_addr_width", {mem_addr, img_width}, 0);
        m_tog = 1'b0;
        model_clear();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        send_cmd(C_PIX, 28'h0AB, 0);

        repeat (5) @(negedge clk);
        check("mem_q_empty", exp_mem_q.size(), 0);
        check("ker_q_empty", exp_ker_q.size(), 0);
        check("start_q_empty", exp_start_q.size(), 0);
        check("stat_q_empty", exp_stat_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/gpio_conv_sequencer.md
Name: gpio_conv_sequencer

Overview:
- Command sequencer between the MicroBlaze 32-bit GPIO pair and the convolution datapath with its image memories.
- Decodes toggle-handshaked command words from the processor: loads image width, kernel coefficients and pixels, starts a convolution, and reads back results and status.
- Sits where the processor-side GPIO glue currently sits, on the same clock as the datapath.

Parameters:
- NB_GPIO, 32, GPIO word width.
- NB_ADDRESS, 10, image memory address width.
- NB_IMAGE, 10, pixel data width.
- NB_COEFF, 8, kernel coefficient width.
- TIMEOUT_CYCLES, 1048576, watchdog limit (only used with the optional feature).

Ports:
- i_CLK  in  1  system clock; all logic is on its rising edge.
- i_rst  in  1  reset, asynchronous, active-high.
- i_gpio_data  in  NB_GPIO  command word from processor GPIO out.
- o_gpio_data  out  NB_GPIO  status/readback word to processor GPIO in.
- o_mem_we  out  1  image memory write strobe.
- o_mem_addr  out  NB_ADDRESS  image memory address.
- o_mem_wdata  out  NB_IMAGE  pixel write data.
- i_mem_rdata  in  NB_IMAGE  result memory read data; 1-cycle read latency.
- o_img_width  out  NB_ADDRESS  configured image width.
- o_kernel_we  out  1  kernel coefficient write strobe.
- o_kernel_idx  out  4  coefficient index, 0..8.
- o_kernel_coeff  out  NB_COEFF  coefficient value.
- o_conv_start  out  1  single-cycle start pulse.
- i_conv_done  in  1  datapath completion; level or pulse, sampled only in RUN.
- o_led  out  3  state indicator.

Behaviour:
- Command word fields:
  - [31:29] opcode.
  - [28] toggle.
  - [27:0] payload.
- Command detection:
  - A command is detected when i_gpio_data[28] differs from the registered previous toggle.
  - Detection takes 1 cycle; the registered toggle updates on the same edge.
- Opcodes:
  - 0 NOP.
  - 1 SOFT_RST.
  - 2 SET_WIDTH: payload[NB_ADDRESS-1:0].
  - 3 WR_KERNEL: idx = payload[11:8], coeff = payload[7:0].
  - 4 WR_PIXEL: data = payload[NB_IMAGE-1:0].
  - 5 START.
  - 6 RD_PIXEL: addr = payload[NB_ADDRESS-1:0].
  - 7 RD_STATUS.
- o_gpio_data fields:
  - [31] ack: equals the accepted toggle once the command completes.
  - [30] busy.
  - [29] done_flag.
  - [28] error.
  - [NB_IMAGE-1:0] read data.
  - All other bits are 0.
- States: IDLE, EXEC, RUN, RD_WAIT.
- o_led encoding: IDLE=001, EXEC=010, RUN=100, RD_WAIT=011; any state with error=1 shows 111.
- Reset values:
  - All outputs 0, except o_led=001.
  - Write pointer 0, o_img_width 0, registered toggle 0.
- IDLE + detect -> EXEC, one cycle later:
  - WR_PIXEL: o_mem_we=1 for exactly 1 cycle, o_mem_addr = write pointer; pointer increments afterwards and wraps from 2^NB_ADDRESS-1 to 0.
  - WR_KERNEL: o_kernel_we 1-cycle pulse. idx > 8 -> no write, error=1.
  - SET_WIDTH: updates o_img_width and clears the write pointer.
  - START: o_conv_start pulse, done_flag cleared, -> RUN.
  - RD_PIXEL: drives the address, -> RD_WAIT; data is latched into o_gpio_data the next cycle, then ack.
  - Other commands: ack in EXEC, -> IDLE.
- Ack timing: ack updates on the cycle the command's effect is visible (WR_* the cycle after the strobe; START on entry to RUN).
- RUN:
  - busy=1.
  - i_conv_done=1 -> done_flag=1, -> IDLE.
  - Commands other than RD_STATUS and SOFT_RST are not executed; they are acked with error=1.
- SOFT_RST: accepted in any state, resets everything as i_rst does except the registered toggle; ack given.
- Error is sticky until SOFT_RST, or until a START that is accepted in IDLE.
- Simultaneous command detect and i_conv_done in RUN: done is processed first; the command is then handled from IDLE on the next cycle.
- A toggle change during RD_WAIT or EXEC is held pending and processed on return to IDLE; only one command is pending at a time.
- i_rst mid-operation: immediate return to reset values; pending strobes are dropped.

Optional Feature:
- Macro: CONV_TIMEOUT_EN.
- Defined:
  - A counter runs in RUN.
  - Reaching TIMEOUT_CYCLES without i_conv_done -> error=1, done_flag=0, -> IDLE.
  - Counter clears on RUN entry.
- Undefined: no counter; RUN waits indefinitely; TIMEOUT_CYCLES is unused.

Decomposition:
- Shared package:
  - Opcode constants.
  - Command field bit positions.
  - Status bit positions.
  - State and LED encodings.
- One sub-module, gpio_toggle_detect:
  - Registers the toggle and produces the detect pulse plus pending-hold.

Test Plan:
- SET_WIDTH 64, then WR_PIXEL x3 with data 5,6,7 -> o_mem_we pulses at addr 0,1,2 with wdata 5,6,7; o_img_width=64; ack follows each toggle.
- WR_KERNEL idx 4 coeff 0x7F -> o_kernel_we pulse with idx 4, coeff 0x7F; idx 9 -> no strobe, error=1, o_led=111.
- START, i_conv_done after 100 cycles -> single o_conv_start pulse, busy=1 for 100 cycles, then done_flag=1, o_led=001.
- WR_PIXEL issued during RUN -> no o_mem_we, ack with error=1; SOFT_RST -> error=0, pointer 0, state IDLE.
- RD_PIXEL addr 3 with i_mem_rdata=0x2A -> o_gpio_data[9:0]=0x2A, then ack; 1024 WR_PIXELs -> pointer wraps to 0.
- CONV_TIMEOUT_EN with TIMEOUT_CYCLES=50, no done -> error=1, state IDLE after 50 cycles; i_rst asserted mid-RUN -> all outputs at reset values immediately.
